decode_stage: RTL
=================

# decode_stage

Registered instruction-decode stage for the pipelined MIPS core; it sits between the fetch/regfile-read boundary and the execute stage. Each accepted instruction is decoded into an ALU/memory/branch control bundle and held in a single-entry ID/EX register behind a valid/ready handshake. The stage adds three things to the single-cycle decoder:
- a load-use interlock
- a HI/LO multiply/divide busy counter
- a pipeline flush

## Interface
- MUL_LAT, 4, cycles HI/LO stays busy after an accepted MULT/MULTU (1..15)
- DIV_LAT, 12, cycles HI/LO stays busy after an accepted DIV/DIVU (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1  fetch-side handshake
- in_pc, in_instr  in  32  instruction and its address
- rs_addr, rt_addr  out  5  combinational from in_instr[25:21], [20:16]
- rs_data, rt_data  in  32  regfile read data, same cycle as in_instr
- ex_load_valid  in  1  a LW occupies the execute stage
- ex_load_dst  in  5  destination of that LW
- flush  in  1  squash the held bundle and refuse input this cycle
- out_valid / out_ready  out / in  1  execute-side handshake
- out_pc  out  32  registered in_pc
- out_alu_opcode  out  4  ALU function code from the shared defines
- out_alu_op_x, out_alu_op_y  out  32  ALU operands
- out_reg_write_en  out  1  write enable
- out_reg_write_addr  out  5  write address
- out_mem_read_en, out_mem_write_en  out  1  LW / SW
- out_branch_en, out_jump_en, out_jump_reg_en  out  1  taken branch, J/JAL, JR/JALR
- out_target  out  32  redirect address, valid when any of the three above is set
- out_muldiv_op  out  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO
- out_illegal  out  1  unrecognised opcode/funct; bundle forced to a NOP otherwise
- muldiv_busy  out  1  HI/LO busy counter is nonzero

## Operation
- Accept condition: accept = in_valid & in_ready.
- Ready: in_ready = ~flush & ~stall & (~out_valid | out_ready).
- Load-use stall: ex_load_valid, ex_load_dst ≠ 0, and ex_load_dst equals a source register the instruction actually reads.
  - rs is read by everything except J, JAL, LUI, SLL, SRA, SRL.
  - rt is read by R-type, BEQ, BNE and SW.
- Mul/div stall: muldiv_busy and the instruction is MULT*, DIV*, MFHI or MFLO.
- ALU decode: same opcode map as the single-cycle decoder.
  - Zero-extended immediate for ANDI/ORI/XORI; sign-extended otherwise.
  - LUI is SLL by 16 of the immediate.
  - Variable shifts take rs_data[4:0] as the shift amount.
- Branches evaluate at accept from rs_data/rt_data. BLEZ/BGTZ compare signed. Branch target = in_pc + 4 + (sext(imm) << 2).
- Jumps:
  - J/JAL target = {(in_pc+4)[31:28], instr[25:0], 2'b00}.
  - JR/JALR target = rs_data.
- Link instructions (JAL, JALR, BLTZAL, BGEZAL):
  - ALU computes in_pc + 8 (delay slot), with op_x = in_pc, op_y = 8, opcode ADD.
  - Write address: JALR writes rd; the others write register 31.
  - BLTZAL/BGEZAL link whether or not the branch is taken.
- Register writes:
  - out_reg_write_en = 0 for SW, J, JR, non-linking branches, MULT*, DIV*, and illegal instructions.
  - Write address 0 is always forced to write-enable 0.
- Busy counter:
  - Accepted MULT* loads MUL_LAT; accepted DIV* loads DIV_LAT.
  - Otherwise the counter decrements while nonzero.
  - Flush does not clear it.

## Timing
- Latency: 1 cycle. Accept at edge N gives out_valid = 1 after edge N with the bundle.
- Bundle hold: stable while out_valid & ~out_ready.
- Simultaneous out fire and accept: the new bundle replaces the old one and out_valid stays 1.
- Out fire with no accept: out_valid drops to 0.
- Flush: out_valid = 0 at the next edge, regardless of out_ready. No accept occurs in the flush cycle.
- Reset: all out_* = 0, out_valid = 0, counter = 0, muldiv_busy = 0. in_ready = 1 in the first cycle after reset.
- Reset during a stall or a busy period: everything is cleared and the pending instruction is dropped.
- Back-to-back MULT: the second one stalls exactly MUL_LAT cycles after the first is accepted.

## Configuration
- MIPS_DECODE_MULDIV_EN defined:
  - MULT/MULTU/DIV/DIVU/MFHI/MFLO decode as described above.
  - Busy counter is present.
  - MFHI/MFLO write rd with out_reg_write_en = 1.
- Undefined:
  - Those six encodings set out_illegal.
  - The counter is removed; muldiv_busy is tied to 0 and out_muldiv_op to 0.
  - The MUL_LAT/DIV_LAT parameters are ignored.

## Structure
- Package mips_decode_pkg holds:
  - the opcode/funct/regimm constants and the ALU opcode codes
  - the muldiv_op encoding
  - a packed struct decode_bundle_t holding all out_* fields except out_valid
- Sub-module decode_ctrl is purely combinational: in_pc, in_instr, rs_data, rt_data → decode_bundle_t plus the rs_used/rt_used flags.
- decode_stage owns the handshake, stall, flush, counter and the bundle register.

## Test plan
- **ADDI:** ADDI $5,$0,-3 (0x2005FFFD) with out_ready = 1 → next cycle out_alu_op_y = 0xFFFFFFFD, out_reg_write_addr = 5, out_reg_write_en = 1.
- **Load-use:** ex_load_valid = 1, ex_load_dst = 8, in ADD $3,$8,$9 → in_ready = 0 while asserted. Dropping ex_load_valid → accepted in the same cycle.
- **JAL:** JAL 0x0040_0010 at in_pc 0x0040_0000 → out_alu_op_x = 0x00400000, op_y = 8, write addr 31, out_target = 0x00400010.
- **BGEZAL:** BGEZAL with rs_data = 0xFFFFFFFF → out_branch_en = 0, out_reg_write_en = 1, addr 31.
- **MULT back-to-back** (macro on, MUL_LAT = 4): MULT, then MFLO presented next cycle → MFLO held exactly 4 cycles after MULT accept. With the macro off → out_illegal = 1.
- **Flush:** flush while out_valid = 1 and out_ready = 0 → out_valid = 0 next cycle; the pending input is not accepted in the flush cycle. Reset mid-stall → all outputs 0.

Source files
------------

// File: rtl/mips_decode_pkg.sv
// Shared encodings for the MIPS decode stage: instruction fields, ALU codes,
// HI/LO operation codes and the registered ID/EX control bundle.
package mips_decode_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] RI_BLTZ   = 5'h00;
    localparam logic [4:0] RI_BGEZ   = 5'h01;
    localparam logic [4:0] RI_BLTZAL = 5'h10;
    localparam logic [4:0] RI_BGEZAL = 5'h11;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_SLL  = 4'd10,
        ALU_SRL  = 4'd11,
        ALU_SRA  = 4'd12
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MFHI  = 3'd5,
        MD_MFLO  = 3'd6
    } muldiv_op_e;

    typedef struct packed {
        logic [31:0] pc;
        alu_op_e     alu_opcode;
        logic [31:0] alu_op_x;
        logic [31:0] alu_op_y;
        logic        reg_write_en;
        logic [4:0]  reg_write_addr;
        logic        mem_read_en;
        logic        mem_write_en;
        logic        branch_en;
        logic        jump_en;
        logic        jump_reg_en;
        logic [31:0] target;
        muldiv_op_e  muldiv_op;
        logic        illegal;
    } decode_bundle_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder producing the ID/EX control bundle and the
// source-register usage flags. HI/LO ops decode only with MIPS_DECODE_MULDIV_EN.
module decode_ctrl
    import mips_decode_pkg::*;
(
    input  logic [31:0]    pc_i,
    input  logic [31:0]    instr_i,
    input  logic [31:0]    rs_data_i,
    input  logic [31:0]    rt_data_i,
    output decode_bundle_t bundle_o,
    output logic           rs_used_o,
    output logic           rt_used_o
);

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    assign opcode        = instr_i[31:26];
    assign rt            = instr_i[20:16];
    assign rd            = instr_i[15:11];
    assign shamt         = instr_i[10:6];
    assign funct         = instr_i[5:0];
    assign imm_sext      = {{16{instr_i[15]}}, instr_i[15:0]};
    assign imm_zext      = {16'h0000, instr_i[15:0]};
    assign pc_plus4      = pc_i + 32'd4;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr_i[25:0], 2'b00};

    always_comb begin
        bundle_o    = '0;
        bundle_o.pc = pc_i;
        rs_used_o   = 1'b1;
        rt_used_o   = 1'b0;

        unique case (opcode)
            OP_SPECIAL: begin
                rt_used_o               = 1'b1;
                bundle_o.alu_op_x       = rs_data_i;
                bundle_o.alu_op_y       = rt_data_i;
                bundle_o.reg_write_en   = 1'b1;
                bundle_o.reg_write_addr = rd;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        rs_used_o         = 1'b0;
                        bundle_o.alu_op_x = rt_data_i;
                        bundle_o.alu_op_y = {27'd0, shamt};
                        bundle_o.alu_opcode = (funct == FN_SLL) ? ALU_SLL :
                                              (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        bundle_o.alu_op_x = rt_data_i;
                        bundle_o.alu_op_y = {27'd0, rs_data_i[4:0]};
                        bundle_o.alu_opcode = (funct == FN_SLLV) ? ALU_SLL :
                                              (funct == FN_SRLV) ? ALU_SRL : ALU_SRA;
                    end
                    FN_JR: begin
                        bundle_o.reg_write_en = 1'b0;
                        bundle_o.jump_reg_en  = 1'b1;
                        bundle_o.target       = rs_data_i;
                    end
                    FN_JALR: begin
                        bundle_o.jump_reg_en = 1'b1;
                        bundle_o.target      = rs_data_i;
                        bundle_o.alu_opcode  = ALU_ADD;
                        bundle_o.alu_op_x    = pc_i;
                        bundle_o.alu_op_y    = 32'd8;
                    end
                    FN_ADD:  bundle_o.alu_opcode = ALU_ADD;
                    FN_ADDU: bundle_o.alu_opcode = ALU_ADDU;
                    FN_SUB:  bundle_o.alu_opcode = ALU_SUB;
                    FN_SUBU: bundle_o.alu_opcode = ALU_SUBU;
                    FN_AND:  bundle_o.alu_opcode = ALU_AND;
                    FN_OR:   bundle_o.alu_opcode = ALU_OR;
                    FN_XOR:  bundle_o.alu_opcode = ALU_XOR;
                    FN_NOR:  bundle_o.alu_opcode = ALU_NOR;
                    FN_SLT:  bundle_o.alu_opcode = ALU_SLT;
                    FN_SLTU: bundle_o.alu_opcode = ALU_SLTU;
`ifdef MIPS_DECODE_MULDIV_EN
                    FN_MFHI, FN_MFLO: begin
                        bundle_o.alu_op_x  = 32'd0;
                        bundle_o.alu_op_y  = 32'd0;
                        bundle_o.muldiv_op = (funct == FN_MFHI) ? MD_MFHI : MD_MFLO;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        bundle_o.reg_write_en = 1'b0;
                        bundle_o.muldiv_op = (funct == FN_MULT)  ? MD_MULT  :
                                             (funct == FN_MULTU) ? MD_MULTU :
                                             (funct == FN_DIV)   ? MD_DIV   : MD_DIVU;
                    end
`endif
                    default: bundle_o.illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                bundle_o.target   = branch_target;
                bundle_o.alu_op_x = rs_data_i;
                case (rt)
                    RI_BLTZ, RI_BLTZAL: bundle_o.branch_en = rs_data_i[31];
                    RI_BGEZ, RI_BGEZAL: bundle_o.branch_en = ~rs_data_i[31];
                    default:            bundle_o.illegal   = 1'b1;
                endcase
                // Linking forms write the return address even when not taken.
                if (rt == RI_BLTZAL || rt == RI_BGEZAL) begin
                    bundle_o.alu_opcode     = ALU_ADD;
                    bundle_o.alu_op_x       = pc_i;
                    bundle_o.alu_op_y       = 32'd8;
                    bundle_o.reg_write_en   = 1'b1;
                    bundle_o.reg_write_addr = LINK_REG;
                end
            end
            OP_J, OP_JAL: begin
                rs_used_o       = 1'b0;
                bundle_o.jump_en = 1'b1;
                bundle_o.target  = jump_target;
                if (opcode == OP_JAL) begin
                    bundle_o.alu_opcode     = ALU_ADD;
                    bundle_o.alu_op_x       = pc_i;
                    bundle_o.alu_op_y       = 32'd8;
                    bundle_o.reg_write_en   = 1'b1;
                    bundle_o.reg_write_addr = LINK_REG;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                rt_used_o           = (opcode == OP_BEQ) || (opcode == OP_BNE);
                bundle_o.alu_opcode = ALU_SUB;
                bundle_o.alu_op_x   = rs_data_i;
                bundle_o.alu_op_y   = rt_used_o ? rt_data_i : 32'd0;
                bundle_o.target     = branch_target;
                case (opcode)
                    OP_BEQ:  bundle_o.branch_en = (rs_data_i == rt_data_i);
                    OP_BNE:  bundle_o.branch_en = (rs_data_i != rt_data_i);
                    OP_BLEZ: bundle_o.branch_en = ($signed(rs_data_i) <= 32'sd0);
                    default: bundle_o.branch_en = ($signed(rs_data_i) > 32'sd0);
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                bundle_o.alu_op_x       = rs_data_i;
                bundle_o.alu_op_y       = imm_sext;
                bundle_o.reg_write_en   = 1'b1;
                bundle_o.reg_write_addr = rt;
                case (opcode)
                    OP_ADDIU: bundle_o.alu_opcode = ALU_ADDU;
                    OP_SLTI:  bundle_o.alu_opcode = ALU_SLT;
                    OP_SLTIU: bundle_o.alu_opcode = ALU_SLTU;
                    OP_ANDI:  begin bundle_o.alu_opcode = ALU_AND; bundle_o.alu_op_y = imm_zext; end
                    OP_ORI:   begin bundle_o.alu_opcode = ALU_OR;  bundle_o.alu_op_y = imm_zext; end
                    OP_XORI:  begin bundle_o.alu_opcode = ALU_XOR; bundle_o.alu_op_y = imm_zext; end
                    OP_LUI: begin
                        rs_used_o           = 1'b0;
                        bundle_o.alu_opcode = ALU_SLL;
                        bundle_o.alu_op_x   = imm_zext;
                        bundle_o.alu_op_y   = 32'd16;
                    end
                    OP_LW: begin
                        bundle_o.alu_opcode  = ALU_ADD;
                        bundle_o.mem_read_en = 1'b1;
                    end
                    default:  bundle_o.alu_opcode = ALU_ADD;
                endcase
            end
            OP_SW: begin
                rt_used_o             = 1'b1;
                bundle_o.alu_opcode   = ALU_ADD;
                bundle_o.alu_op_x     = rs_data_i;
                bundle_o.alu_op_y     = imm_sext;
                bundle_o.mem_write_en = 1'b1;
            end
            default: bundle_o.illegal = 1'b1;
        endcase

        if (bundle_o.illegal) begin
            bundle_o         = '0;
            bundle_o.pc      = pc_i;
            bundle_o.illegal = 1'b1;
        end
        if (bundle_o.reg_write_addr == 5'd0) begin
            bundle_o.reg_write_en = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered ID/EX stage: valid/ready handshake, load-use and HI/LO interlocks,
// flush. The HI/LO busy counter exists only with MIPS_DECODE_MULDIV_EN.
module decode_stage #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_load_valid,
    input  logic [4:0]  ex_load_dst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_alu_opcode,
    output logic [31:0] out_alu_op_x,
    output logic [31:0] out_alu_op_y,
    output logic        out_reg_write_en,
    output logic [4:0]  out_reg_write_addr,
    output logic        out_mem_read_en,
    output logic        out_mem_write_en,
    output logic        out_branch_en,
    output logic        out_jump_en,
    output logic        out_jump_reg_en,
    output logic [31:0] out_target,
    output logic [2:0]  out_muldiv_op,
    output logic        out_illegal,
    output logic        muldiv_busy
);
    import mips_decode_pkg::*;

    decode_bundle_t dec_bundle;
    decode_bundle_t bundle_q, bundle_d;
    logic           out_valid_q, out_valid_d;
    logic           rs_used, rt_used;
    logic           load_use_stall, muldiv_stall, stall, accept;

    decode_ctrl u_ctrl (
        .pc_i      (in_pc),
        .instr_i   (in_instr),
        .rs_data_i (rs_data),
        .rt_data_i (rt_data),
        .bundle_o  (dec_bundle),
        .rs_used_o (rs_used),
        .rt_used_o (rt_used)
    );

    assign rs_addr = in_instr[25:21];
    assign rt_addr = in_instr[20:16];

    assign load_use_stall = ex_load_valid && (ex_load_dst != 5'd0) &&
                            ((rs_used && ex_load_dst == rs_addr) ||
                             (rt_used && ex_load_dst == rt_addr));
    // MFHI/MFLO wait too, not only a second MULT/DIV.
    assign muldiv_stall   = muldiv_busy && (dec_bundle.muldiv_op != MD_NONE);
    assign stall          = load_use_stall || muldiv_stall;
    assign in_ready       = ~flush & ~stall & (~out_valid_q | out_ready);
    assign accept         = in_valid & in_ready;

`ifdef MIPS_DECODE_MULDIV_EN
    logic [3:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (accept && (dec_bundle.muldiv_op == MD_MULT || dec_bundle.muldiv_op == MD_MULTU)) begin
            busy_cnt_d = 4'(MUL_LAT);
        end else if (accept && (dec_bundle.muldiv_op == MD_DIV || dec_bundle.muldiv_op == MD_DIVU)) begin
            busy_cnt_d = 4'(DIV_LAT);
        end else if (busy_cnt_q != 4'd0) begin
            busy_cnt_d = busy_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= 4'd0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign muldiv_busy = (busy_cnt_q != 4'd0);
`else
    localparam int unused_lat = MUL_LAT + DIV_LAT;
    assign muldiv_busy = 1'b0;
`endif

    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            bundle_d    = dec_bundle;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_pc             = bundle_q.pc;
    assign out_alu_opcode     = bundle_q.alu_opcode;
    assign out_alu_op_x       = bundle_q.alu_op_x;
    assign out_alu_op_y       = bundle_q.alu_op_y;
    assign out_reg_write_en   = bundle_q.reg_write_en;
    assign out_reg_write_addr = bundle_q.reg_write_addr;
    assign out_mem_read_en    = bundle_q.mem_read_en;
    assign out_mem_write_en   = bundle_q.mem_write_en;
    assign out_branch_en      = bundle_q.branch_en;
    assign out_jump_en        = bundle_q.jump_en;
    assign out_jump_reg_en    = bundle_q.jump_reg_en;
    assign out_target         = bundle_q.target;
    assign out_muldiv_op      = bundle_q.muldiv_op;
    assign out_illegal        = bundle_q.illegal;

endmodule
